// File: rtl/asc_instr_loader_if.sv
// ----------------------------------------------------------------------------
// asc_instr_loader_if
// Bundles the two handshakes around the ASCII instruction loader:
//   - character stream in  : ch_valid / ch_ready / ch_data
//   - instruction-memory write port : wr_en / wr_ready / wr_addr / wr_data
//   - line status           : err / err_cnt / digit_cnt
// Modports:
//   slave  - the loader itself (consumes characters, issues writes)
//   master - the environment (character source + instruction memory)
// Parameter:
//   ADDR_W - instruction-memory word address width
// ----------------------------------------------------------------------------
interface asc_instr_loader_if #(
    parameter int ADDR_W = 8
);
    logic              ch_valid;
    logic              ch_ready;
    logic [7:0]        ch_data;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              err;
    logic [7:0]        err_cnt;
    logic [3:0]        digit_cnt;

    modport slave (
        input  ch_valid,
        input  ch_data,
        input  wr_ready,
        output ch_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output err,
        output err_cnt,
        output digit_cnt
    );

    modport master (
        output ch_valid,
        output ch_data,
        output wr_ready,
        input  ch_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  err,
        input  err_cnt,
        input  digit_cnt
    );
endinterface

// File: rtl/asc_instr_loader.sv
// ----------------------------------------------------------------------------
// asc_instr_loader
// Turns a stream of ASCII hex characters into 32-bit MIPS instruction words
// and writes each completed word to instruction memory at an auto-incrementing
// word address (wrapping modulo 2**ADDR_W).
//
// A line is 8 hex digits (0-9, A-F, a-f) closed by LF or CR. Spaces and '_'
// are cosmetic separators, backspace (0x08) removes the last digit. Short
// lines, overlong lines and lines containing any other byte are rejected
// with a one-cycle err pulse and counted in err_cnt (saturating at 255).
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - asc_instr_loader_if.slave
//            ch_valid/ch_ready/ch_data : character stream
//            wr_en/wr_ready/wr_addr/wr_data : instruction-memory write port
//            err/err_cnt/digit_cnt : line status
//
// Build option:
//   OPCODE_CHECK_EN - when defined, a complete word whose opcode (bits 31:26)
//                     is not one the pipeline implements is rejected instead
//                     of written.
//
// state   | meaning
// --------+------------------------------------------------------------------
// COLLECT | accepting characters, assembling the current line
// HOLD    | word complete, wr_en asserted until memory takes it
// DISCARD | line already rejected, dropping characters up to the terminator
// ----------------------------------------------------------------------------
module asc_instr_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    asc_instr_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [31:0]       word, word_n;
    logic [3:0]        digit_cnt, digit_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [31:0]       wr_data, wr_data_n;
    logic              err, err_n;
    logic [7:0]        err_cnt, err_cnt_n;

    logic              ch_take;
    logic [7:0]        ch;
    logic              ch_hex;
    logic [3:0]        ch_nib;
    logic              ch_bs;
    logic              ch_skip;
    logic              ch_term;
    logic              opcode_ok;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    assign ch = bus.ch_data;

    always_comb begin
        ch_hex = 1'b0;
        ch_nib = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            ch_hex = 1'b1;
            ch_nib = ch[3:0];
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            // 'A'..'F' have low nibble 1..6, so +9 yields 10..15
            ch_hex = 1'b1;
            ch_nib = ch[3:0] + 4'd9;
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            ch_hex = 1'b1;
            ch_nib = ch[3:0] + 4'd9;
        end
    end

    assign ch_bs   = (ch == 8'h08);
    assign ch_skip = (ch == 8'h20) || (ch == 8'h5F);
    assign ch_term = (ch == 8'h0A) || (ch == 8'h0D);

    // ------------------------------------------------------------------
    // Opcode filter
    // ------------------------------------------------------------------
`ifdef OPCODE_CHECK_EN
    always_comb begin
        case (word[31:26])
            6'h00,                  // R-type
            6'h23,                  // LW
            6'h2B,                  // SW
            6'h04,                  // BEQ
            6'h05,                  // BNE
            6'h02,                  // J
            6'h08,                  // ADDI
            6'h0C,                  // ANDI
            6'h0D:                  // ORI
                opcode_ok = 1'b1;
            default:
                opcode_ok = 1'b0;
        endcase
    end
`else
    assign opcode_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Handshake outputs follow directly from the registered state, so
    // wr_en rises in the cycle after the terminator is consumed.
    // ------------------------------------------------------------------
    assign bus.ch_ready  = (state != HOLD);
    assign bus.wr_en     = (state == HOLD);
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.err       = err;
    assign bus.err_cnt   = err_cnt;
    assign bus.digit_cnt = digit_cnt;

    assign ch_take = bus.ch_valid && (state != HOLD);

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        word_n    = word;
        digit_n   = digit_cnt;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        err_n     = 1'b0;
        err_cnt_n = err_cnt;

        case (state)
            COLLECT: begin
                if (ch_take) begin
                    if (ch_hex) begin
                        if (digit_cnt == 4'd8) begin
                            // ninth digit: line is too long
                            err_n   = 1'b1;
                            state_n = DISCARD;
                        end else begin
                            word_n  = {word[27:0], ch_nib};
                            digit_n = digit_cnt + 4'd1;
                        end
                    end else if (ch_bs) begin
                        if (digit_cnt != 4'd0) begin
                            word_n  = {4'h0, word[31:4]};
                            digit_n = digit_cnt - 4'd1;
                        end
                    end else if (ch_skip) begin
                        // separators are purely cosmetic
                    end else if (ch_term) begin
                        if (digit_cnt == 4'd8) begin
                            if (opcode_ok) begin
                                wr_data_n = word;
                                state_n   = HOLD;
                            end else begin
                                err_n   = 1'b1;
                                digit_n = 4'd0;
                                word_n  = 32'h0;
                            end
                        end else if (digit_cnt != 4'd0) begin
                            // short line; the terminator itself ends it,
                            // so there is nothing left to discard
                            err_n   = 1'b1;
                            digit_n = 4'd0;
                            word_n  = 32'h0;
                        end
                    end else begin
                        err_n   = 1'b1;
                        state_n = DISCARD;
                    end
                end
            end

            DISCARD: begin
                if (ch_take && ch_term) begin
                    digit_n = 4'd0;
                    word_n  = 32'h0;
                    state_n = COLLECT;
                end
            end

            HOLD: begin
                if (bus.wr_ready) begin
                    wr_addr_n = wr_addr + ADDR_W'(1);
                    digit_n   = 4'd0;
                    word_n    = 32'h0;
                    state_n   = COLLECT;
                end
            end

            default: begin
                state_n = COLLECT;
                digit_n = 4'd0;
                word_n  = 32'h0;
            end
        endcase

        if (err_n && (err_cnt != 8'hFF)) begin
            err_cnt_n = err_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            word      <= 32'h0;
            digit_cnt <= 4'd0;
            wr_addr   <= '0;
            wr_data   <= 32'h0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            state     <= state_n;
            word      <= word_n;
            digit_cnt <= digit_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            err       <= err_n;
            err_cnt   <= err_cnt_n;
        end
    end

endmodule
